// File: rtl/pp_trace_buffer.sv
// Retire-trace capture buffer: stamps each retired instruction with a cycle count and stores it
// in a circular store (wrap / stop-when-full / PC-trigger), drained through a valid/ready port.
//   state     | meaning
//   ST_ARMED  | capturing, waiting for a trigger PC match (mode 2 only)
//   ST_POST   | capturing the post-trigger window, r_rem entries left
//   ST_FROZEN | capture stopped after the trigger window; readout continues
module pp_trace_buffer #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 16,
   parameter int TS_W   = 16,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1,
   localparam int REC_W = 2*ADDR_W + 3*DATA_W + 7
) (
   input  logic              clk,
   input  logic              rstb,
   input  logic              clr,
   input  logic              cap_en,
   input  logic [1:0]        mode,
   input  logic [ADDR_W-1:0] trig_pc,
   input  logic [CNT_W-1:0]  post_cnt,
   input  logic              ev_valid,
   input  logic [ADDR_W-1:0] ev_pc,
   input  logic [DATA_W-1:0] ev_instr,
   input  logic              ev_rd_we,
   input  logic [4:0]        ev_rd,
   input  logic [DATA_W-1:0] ev_rd_data,
   input  logic              ev_mem_we,
   input  logic [ADDR_W-1:0] ev_mem_addr,
   input  logic [DATA_W-1:0] ev_mem_data,
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic [REC_W-1:0]  rd_record,
   output logic [TS_W-1:0]   rd_ts,
   output logic [CNT_W-1:0]  count,
   output logic              full,
   output logic              overflow,
   output logic              triggered,
   output logic              done
);

   typedef enum logic [1:0] {ST_ARMED = 2'd0, ST_POST = 2'd1, ST_FROZEN = 2'd2} state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [CNT_W-1:0]    r_rem;
   logic [CNT_W-1:0]    w_rem_nxt;
   logic [1:0]          r_mode;
   logic [TS_W-1:0]     r_ts;
   logic [CNT_W-1:0]    r_cnt;
   logic [PTR_W-1:0]    r_wptr;
   logic [PTR_W-1:0]    r_rptr;
   logic                r_ovf;
   logic                r_trig;
   logic [REC_W-1:0]    r_mem_rec [DEPTH];
   logic [TS_W-1:0]     r_mem_ts  [DEPTH];

   logic                w_full;
   logic                w_valid;
   logic                w_cap;
   logic                w_pop;
   logic                w_drop;
   logic                w_ovwr;
   logic                w_write;
   logic                w_trig_hit;
   logic                w_done;
   logic [REC_W-1:0]    w_ev_rec;

   assign w_full   = (r_cnt == CNT_W'(DEPTH));
   assign w_valid  = (r_cnt != '0);
   assign w_cap    = rstb & ev_valid & cap_en & (r_state != ST_FROZEN) & ~clr;
   assign w_pop    = rstb & w_valid & rd_ready & ~clr;
   // Only stop-when-full drops; every other mode overwrites the oldest entry.
   assign w_drop   = w_cap & w_full & ~w_pop & (r_mode == 2'd1);
   assign w_ovwr   = w_cap & w_full & ~w_pop & (r_mode != 2'd1);
   assign w_write  = w_cap & ~w_drop;
   assign w_trig_hit = w_cap & (r_mode == 2'd2) & (r_state == ST_ARMED) & (ev_pc == trig_pc);
   assign w_ev_rec = {ev_pc, ev_instr, ev_rd_we, ev_rd, ev_rd_data, ev_mem_we, ev_mem_addr, ev_mem_data};

   always_ff @(posedge clk) begin
      if (!rstb || clr) begin
         r_state <= ST_ARMED;
         r_rem   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_rem   <= w_rem_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_rem_nxt   = r_rem;
      case (r_state)
         ST_ARMED: begin
            if (w_trig_hit) begin
               w_rem_nxt   = post_cnt;
               w_state_nxt = (post_cnt == '0) ? ST_FROZEN : ST_POST;
            end
         end
         ST_POST: begin
            if (w_cap) begin
               w_rem_nxt = r_rem - CNT_W'(1);
               if (r_rem == CNT_W'(1)) w_state_nxt = ST_FROZEN;
            end
         end
         ST_FROZEN: ;
         default: w_state_nxt = ST_ARMED;
      endcase
   end

   always_comb begin
      w_done = (r_state == ST_FROZEN);
   end

   // Timestamp keeps running through clr so traces across clears stay ordered.
   always_ff @(posedge clk) begin
      if (!rstb) begin
         r_ts   <= '0;
         r_mode <= mode;
         r_cnt  <= '0;
         r_wptr <= '0;
         r_rptr <= '0;
         r_ovf  <= 1'b0;
         r_trig <= 1'b0;
      end else begin
         r_ts <= r_ts + TS_W'(1);
         if (clr) begin
            r_mode <= mode;
            r_cnt  <= '0;
            r_wptr <= '0;
            r_rptr <= '0;
            r_ovf  <= 1'b0;
            r_trig <= 1'b0;
         end else begin
            if (w_write) r_wptr <= r_wptr + PTR_W'(1);
            if (w_pop || w_ovwr) r_rptr <= r_rptr + PTR_W'(1);
            if (w_drop || w_ovwr) r_ovf <= 1'b1;
            if (w_trig_hit) r_trig <= 1'b1;
            if (w_write && !w_pop && !w_ovwr) r_cnt <= r_cnt + CNT_W'(1);
            else if (w_pop && !w_write) r_cnt <= r_cnt - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_write) begin
         r_mem_rec[r_wptr] <= w_ev_rec;
         r_mem_ts[r_wptr]  <= r_ts;
      end
   end

   // Outputs are gated by valid so an empty buffer always reads as zero.
   assign rd_valid  = w_valid;
   assign rd_record = w_valid ? r_mem_rec[r_rptr] : '0;
   assign rd_ts     = w_valid ? r_mem_ts[r_rptr] : '0;
   assign count     = r_cnt;
   assign full      = w_full;
   assign overflow  = r_ovf;
   assign triggered = r_trig;
   assign done      = w_done;

endmodule

// File: tb/tb_pp_trace_buffer.sv
// Bench for pp_trace_buffer: queue-based reference model checked every cycle, directed
// scenarios with literal expectations, then a long randomized run.
module tb_pp_trace_buffer;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int DEPTH  = 16;
   localparam int TS_W   = 16;
   localparam int CNT_W  = 5;
   localparam int REC_W  = 2*ADDR_W + 3*DATA_W + 7;

   logic              clk;
   logic              rstb;
   logic              clr;
   logic              cap_en;
   logic [1:0]        mode;
   logic [ADDR_W-1:0] trig_pc;
   logic [CNT_W-1:0]  post_cnt;
   logic              ev_valid;
   logic [ADDR_W-1:0] ev_pc;
   logic [DATA_W-1:0] ev_instr;
   logic              ev_rd_we;
   logic [4:0]        ev_rd;
   logic [DATA_W-1:0] ev_rd_data;
   logic              ev_mem_we;
   logic [ADDR_W-1:0] ev_mem_addr;
   logic [DATA_W-1:0] ev_mem_data;
   logic              rd_valid;
   logic              rd_ready;
   logic [REC_W-1:0]  rd_record;
   logic [TS_W-1:0]   rd_ts;
   logic [CNT_W-1:0]  count;
   logic              full;
   logic              overflow;
   logic              triggered;
   logic              done;

   pp_trace_buffer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .TS_W(TS_W)) dut (
      .clk(clk), .rstb(rstb), .clr(clr), .cap_en(cap_en), .mode(mode),
      .trig_pc(trig_pc), .post_cnt(post_cnt), .ev_valid(ev_valid), .ev_pc(ev_pc),
      .ev_instr(ev_instr), .ev_rd_we(ev_rd_we), .ev_rd(ev_rd), .ev_rd_data(ev_rd_data),
      .ev_mem_we(ev_mem_we), .ev_mem_addr(ev_mem_addr), .ev_mem_data(ev_mem_data),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_record(rd_record), .rd_ts(rd_ts),
      .count(count), .full(full), .overflow(overflow), .triggered(triggered), .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [REC_W-1:0] rec;
      logic [TS_W-1:0]  ts;
   } ent_t;

   ent_t mq[$];
   int   m_ts;
   bit   m_ovf;
   bit   m_trig;
   bit   m_frozen;
   int   m_rem;
   int   m_mode;
   int   n_checks = 0;
   int   n_errors = 0;
   bit   chk_en = 1'b0;

   task automatic check(input string name, input logic [REC_W-1:0] act, input logic [REC_W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: the buffer is a queue, the trigger window a countdown.
   always @(posedge clk) begin : model
      ent_t e;
      bit   pop;
      bit   cap;
      if (!rstb) begin
         mq.delete();
         m_ovf = 0; m_trig = 0; m_frozen = 0; m_rem = 0; m_mode = int'(mode); m_ts = 0;
      end else begin
         if (clr) begin
            mq.delete();
            m_ovf = 0; m_trig = 0; m_frozen = 0; m_rem = 0; m_mode = int'(mode);
         end else begin
            pop = (mq.size() != 0) && rd_ready;
            cap = ev_valid && cap_en && !m_frozen;
            if (cap) begin
               e.rec = {ev_pc, ev_instr, ev_rd_we, ev_rd, ev_rd_data, ev_mem_we, ev_mem_addr, ev_mem_data};
               e.ts  = TS_W'(m_ts);
               if (pop) begin
                  void'(mq.pop_front());
                  mq.push_back(e);
               end else if (mq.size() == DEPTH) begin
                  m_ovf = 1;
                  if (m_mode != 1) begin
                     void'(mq.pop_front());
                     mq.push_back(e);
                  end
               end else begin
                  mq.push_back(e);
               end
               if (m_mode == 2) begin
                  if (!m_trig) begin
                     if (ev_pc == trig_pc) begin
                        m_trig = 1;
                        m_rem  = int'(post_cnt);
                        if (m_rem == 0) m_frozen = 1;
                     end
                  end else begin
                     m_rem--;
                     if (m_rem == 0) m_frozen = 1;
                  end
               end
            end else if (pop) begin
               void'(mq.pop_front());
            end
         end
         m_ts = (m_ts + 1) % (1 << TS_W);
      end
   end

   always @(negedge clk) begin : compare
      if (chk_en) begin
         check("rd_valid", REC_W'(rd_valid), REC_W'(mq.size() != 0));
         check("count", REC_W'(count), REC_W'(mq.size()));
         check("full", REC_W'(full), REC_W'(mq.size() == DEPTH));
         check("overflow", REC_W'(overflow), REC_W'(m_ovf));
         check("triggered", REC_W'(triggered), REC_W'(m_trig));
         check("done", REC_W'(done), REC_W'(m_frozen));
         if (mq.size() != 0) begin
            check("rd_record", rd_record, mq[0].rec);
            check("rd_ts", REC_W'(rd_ts), REC_W'(mq[0].ts));
         end else begin
            check("rd_record_empty", rd_record, '0);
            check("rd_ts_empty", REC_W'(rd_ts), '0);
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ev(input logic [ADDR_W-1:0] pc);
      ev_valid    = 1'b1;
      ev_pc       = pc;
      ev_instr    = $urandom;
      ev_rd_we    = 1'($urandom);
      ev_rd       = 5'($urandom);
      ev_rd_data  = $urandom;
      ev_mem_we   = 1'($urandom);
      ev_mem_addr = $urandom;
      ev_mem_data = $urandom;
   endtask

   task automatic do_clr(input logic [1:0] md);
      mode = md;
      clr  = 1'b1;
      cyc();
      clr  = 1'b0;
   endtask

   task automatic push_seq(input int n, input logic [ADDR_W-1:0] start);
      for (int i = 0; i < n; i++) begin
         set_ev(start + ADDR_W'(4*i));
         cyc();
      end
      ev_valid = 1'b0;
   endtask

   initial begin
      rstb = 1'b0; clr = 1'b0; cap_en = 1'b1; mode = 2'd1; trig_pc = '0; post_cnt = '0;
      rd_ready = 1'b0;
      set_ev(32'h1234);
      cyc();
      cyc();
      chk_en = 1'b1;
      check("rst_valid", REC_W'(rd_valid), '0);
      check("rst_count", REC_W'(count), '0);
      check("rst_record", rd_record, '0);
      ev_valid = 1'b0;
      rstb = 1'b1;

      // stop-when-full
      push_seq(20, 32'h0);
      check("m1_count", REC_W'(count), REC_W'(16));
      check("m1_full", REC_W'(full), REC_W'(1));
      check("m1_ovf", REC_W'(overflow), REC_W'(1));
      rd_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         check("m1_drain_pc", REC_W'(rd_record[REC_W-1 -: ADDR_W]), REC_W'(4*i));
         check("m1_drain_ts", REC_W'(rd_ts), REC_W'(i));
         cyc();
      end
      rd_ready = 1'b0;
      check("m1_empty", REC_W'(count), '0);

      // continuous wrap
      do_clr(2'd0);
      push_seq(20, 32'h0);
      check("m0_ovf", REC_W'(overflow), REC_W'(1));
      rd_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         check("m0_drain_pc", REC_W'(rd_record[REC_W-1 -: ADDR_W]), REC_W'(32'h10 + 4*i));
         cyc();
      end
      rd_ready = 1'b0;

      // PC trigger with a post window of 3; mode input wiggles without clr
      trig_pc = 32'h20; post_cnt = 5'd3;
      do_clr(2'd2);
      mode = 2'd0;
      for (int i = 0; i < 16; i++) begin
         set_ev(ADDR_W'(4*i));
         cyc();
         if (i == 7)  check("m2_trig_before", REC_W'(triggered), '0);
         if (i == 8)  check("m2_trig_after", REC_W'(triggered), REC_W'(1));
         if (i == 10) check("m2_done_before", REC_W'(done), '0);
         if (i == 11) check("m2_done_after", REC_W'(done), REC_W'(1));
      end
      ev_valid = 1'b0;
      check("m2_count", REC_W'(count), REC_W'(12));
      rd_ready = 1'b1;
      for (int i = 0; i < 11; i++) cyc();
      rd_ready = 1'b0;
      check("m2_last_pc", REC_W'(rd_record[REC_W-1 -: ADDR_W]), REC_W'(32'h2c));
      do_clr(2'd2);
      check("m2_clr_count", REC_W'(count), '0);
      check("m2_clr_done", REC_W'(done), '0);

      // trigger with empty post window
      trig_pc = 32'h08; post_cnt = 5'd0;
      do_clr(2'd2);
      mode = 2'd3;
      for (int i = 0; i < 16; i++) begin
         set_ev(ADDR_W'(4*i));
         cyc();
         if (i == 1) check("m2z_done_before", REC_W'(done), '0);
         if (i == 2) check("m2z_done_after", REC_W'(done), REC_W'(1));
      end
      ev_valid = 1'b0;
      check("m2z_count", REC_W'(count), REC_W'(3));

      // full buffer with push and pop together
      do_clr(2'd0);
      push_seq(16, 32'h0);
      rd_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         set_ev(ADDR_W'(32'h100 + 4*i));
         cyc();
         check("pp_count", REC_W'(count), REC_W'(16));
         check("pp_ovf", REC_W'(overflow), '0);
      end
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 3) != 0) set_ev(ADDR_W'(32'h200 + 4*i));
         else ev_valid = 1'b0;
         rd_ready = 1'($urandom);
         cyc();
      end
      ev_valid = 1'b0; rd_ready = 1'b0;

      // capture disabled
      do_clr(2'd0);
      cap_en = 1'b0;
      push_seq(8, 32'h40);
      check("capen_count", REC_W'(count), '0);
      cap_en = 1'b1;

      // clr beats a concurrent push and pop
      push_seq(4, 32'h80);
      set_ev(32'h90);
      rd_ready = 1'b1;
      clr = 1'b1;
      cyc();
      clr = 1'b0; ev_valid = 1'b0; rd_ready = 1'b0;
      check("clr_pp_count", REC_W'(count), '0);
      check("clr_pp_valid", REC_W'(rd_valid), '0);

      // reset in the middle of a drain
      mode = 2'd0;
      push_seq(6, 32'hc0);
      rd_ready = 1'b1;
      cyc();
      cyc();
      rstb = 1'b0;
      cyc();
      check("rst_mid_valid", REC_W'(rd_valid), '0);
      check("rst_mid_count", REC_W'(count), '0);
      check("rst_mid_record", rd_record, '0);
      check("rst_mid_ts", REC_W'(rd_ts), '0);
      rstb = 1'b1; rd_ready = 1'b0;

      // randomized run
      for (int i = 0; i < 4000; i++) begin
         int rd_bias;
         rd_bias  = ((i / 500) % 2 == 0) ? 20 : 70;
         rstb     = ($urandom_range(0, 599) != 0);
         clr      = ($urandom_range(0, 119) == 0);
         mode     = 2'($urandom);
         cap_en   = ($urandom_range(0, 9) != 0);
         trig_pc  = ADDR_W'(4 * $urandom_range(0, 15));
         post_cnt = CNT_W'($urandom_range(0, DEPTH));
         rd_ready = ($urandom_range(0, 99) < rd_bias);
         if ($urandom_range(0, 3) != 0) set_ev(ADDR_W'(4 * $urandom_range(0, 15)));
         else ev_valid = 1'b0;
         cyc();
      end
      rstb = 1'b1; clr = 1'b0; ev_valid = 1'b0; rd_ready = 1'b0;
      cyc();
      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule

// File: doc/pp_trace_buffer.md
# pp_trace_buffer

Synthesizable retire-trace capture buffer for the pipelined processor. It records one entry per retired instruction: PC, instruction word, register-file write and data-memory write, each tagged with a cycle timestamp. Entries go into a parametrised circular store with continuous, stop-when-full and PC-trigger modes, and are drained through a valid/ready port. It sits beside the writeback stage and replaces per-cycle hierarchical dumps of PC, memory and register-file state.

## Interface
- ADDR_W, 32, PC and memory address width
- DATA_W, 32, instruction, register and memory data width
- DEPTH, 16, entry count; power of two, at least 2
- TS_W, 16, timestamp width
- clk  in  1  clock; all logic on the rising edge
- rstb  in  1  reset, synchronous, active-low
- clr  in  1  synchronous clear: empty the buffer, clear flags, re-latch mode, re-arm
- cap_en  in  1  capture enable
- mode  in  2  0 = continuous wrap, 1 = stop-when-full, 2 = PC trigger, 3 = reserved (behaves as 0)
- trig_pc  in  ADDR_W  trigger PC for mode 2
- post_cnt  in  log2(DEPTH)+1  number of entries captured after the trigger entry
- ev_valid  in  1  one instruction retires this cycle
- ev_pc, ev_mem_addr  in  ADDR_W  retiring PC; store address
- ev_instr, ev_rd_data, ev_mem_data  in  DATA_W  instruction word; writeback data; store data
- ev_rd_we, ev_mem_we  in  1  register write and memory write flags
- ev_rd  in  5  destination register
- rd_valid  out  1  oldest entry available
- rd_ready  in  1  consumer accepts the entry
- rd_record  out  ADDR_W*2+DATA_W*3+7  packed {pc, instr, rd_we, rd, rd_data, mem_we, mem_addr, mem_data}, MSB first
- rd_ts  out  TS_W  timestamp of the entry
- count  out  log2(DEPTH)+1  occupied entries
- full, overflow, triggered, done  out  1  status flags

## Operation
- Timestamp counter: free-running from 0 after reset, wraps at 2^TS_W. It is not cleared by clr. The event is stamped with the counter value in its capture cycle.
- Capture condition: ev_valid & cap_en & state != FROZEN & !clr. Events that fail this condition are ignored and leave no flag.
- Mode is latched on reset and on clr only. Changes to the mode input at any other time have no effect.
- FSM states:
  - ARMED: capture events.
  - POST: capture events and decrement the remaining post-trigger count.
  - FROZEN: ignore events; readout continues.
- Mode 0: always ARMED. A push while full and not popping overwrites the oldest entry: the read pointer advances, count stays DEPTH, and overflow is set (sticky).
- Mode 1: a push while full and not popping is dropped and sets overflow. Capture resumes once space frees.
- Mode 2: ARMED wraps as in mode 0.
  - A captured event with ev_pc == trig_pc while ARMED is stored and sets triggered.
  - The remaining count loads post_cnt. The next state is POST, or FROZEN if post_cnt == 0.
  - In POST, each captured event decrements remaining; the event that brings it to 0 moves the state to FROZEN.
  - POST overwrite behaviour matches mode 0.
  - A trig_pc match while in POST is not a new trigger.
- done = (state == FROZEN). triggered and done stay set until clr or reset.
- Readout: pop when rd_valid & rd_ready.
  - rd_record and rd_ts show the oldest entry whenever rd_valid = 1.
  - rd_valid = (count != 0).
- Simultaneous push and pop:
  - count unchanged; no overflow, even when full.
  - When count == 1, the popped entry is the old one and the new entry becomes the head next cycle.
- clr has priority over push and pop: count = 0, pointers = 0, flags = 0, state = ARMED.

## Timing
- Reset values (rstb = 0 at a rising edge): rd_valid 0, rd_record 0, rd_ts 0, count 0, full 0, overflow 0, triggered 0, done 0, timestamp 0, state ARMED.
- Event at edge N is visible on rd_valid/rd_record after edge N (one-cycle latency).
- count, full, flags and state are all registered and update on the same edge as the push/pop that changes them.
- full = (count == DEPTH).
- Reset or clr asserted mid-capture or mid-readout discards all contents on that edge. The partially popped head is lost and no output glitches.
- rd_record is stable while rd_valid = 1 and rd_ready = 0, except in mode 0/POST when an overwrite while full advances the head.

## Test plan
- Mode 1, DEPTH = 16: push 20 events with PC 0x0..0x4C, no reads.
  - Required: count = 16, full = 1, overflow = 1.
  - Draining yields PCs 0x00..0x3C in order, with timestamps increasing by 1.
- Mode 0: same stimulus.
  - Required: overflow = 1; drain yields PCs 0x10..0x4C.
- Mode 2: trig_pc = 0x20, post_cnt = 3, push PCs 0x00..0x3C, one per cycle.
  - Required: triggered set the cycle after 0x20; done set after 0x2C; last entry 0x2C; count = 12.
  - After clr, count = 0 and done = 0.
- Mode 2 with post_cnt = 0, trigger on 0x08.
  - Required: done set immediately after 0x08; the following events are ignored.
- Full buffer with simultaneous push and pop every cycle for 10 cycles, rd_ready random otherwise.
  - Required: count stays 16, overflow stays 0, entries come out in strict PC order.
- Reset and clr corner cases:
  - cap_en = 0 during an ev_valid burst: count stays 0.
  - clr asserted together with ev_valid and pop: count = 0 next cycle.
  - rstb low mid-drain: all outputs 0 next cycle.
